calc_queue: RTL
===============

Name: calc_queue

Overview:
- Operand queue for the queue calculator. It sits directly downstream of the ALU and consumes its `result`, `queue_op` and `has_calc_err` outputs.
- It also feeds the ALU its `operands` input, which holds the two head entries, closing the calculator datapath loop.
- It is a circular FIFO of 8-bit values with a small halt-on-error FSM and occupancy status.

Parameters:
- DEPTH, 16, number of entries; must be a power of two and at least 4.
- WIDTH, 8, entry width; must match the ALU result width.
- Q_PUSH, 2'b00, queue op: append `result` at the tail.
- Q_SLEEP, 2'b01, queue op: no change.
- Q_POP, 2'b11, queue op: discard the head entry.
- Q_GET_AND_PUSH, 2'b10, queue op: discard the two head entries, then append `result`.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- op_valid  in  1  strobe; `queue_op`, `result` and `has_calc_err` are sampled only when it is high.
- queue_op  in  2  operation code from the ALU.
- result  in  WIDTH  value to append, from the ALU.
- has_calc_err  in  1  ALU arithmetic error (divide or remainder by zero, bad opcode).
- err_clr  in  1  leaves the HALT state.
- operands  out  2*WIDTH  {entry at head+1, entry at head}, to the ALU.
- count  out  $clog2(DEPTH)+1  current occupancy.
- empty  out  1  high when count==0.
- full  out  1  high when count==DEPTH.
- halted  out  1  high in the HALT state.
- err_code  out  2  cause of the halt: 00 none, 01 overflow, 10 underflow, 11 calc error.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high.
- On a `rst` edge:
  - head, tail and count go to 0; state goes to RUN; err_code goes to 00.
  - Memory contents are not cleared.
  - `rst` overrides every other input in the same cycle, including mid-operation.
- Combinational outputs:
  - operands[WIDTH-1:0] = mem[head] when count>=1, else 0.
  - operands[2*WIDTH-1:WIDTH] = mem[head+1 mod DEPTH] when count>=2, else 0.
  - empty, full and halted are decoded from registers.
- Latency: one cycle. An op accepted at edge N is reflected in count and operands right after edge N.
- FSM states are RUN and HALT.
- In RUN, with op_valid=1, conditions are evaluated in this priority order:
  1. has_calc_err=1: no queue change; go to HALT; err_code=11.
  2. Q_PUSH with full: no change; go to HALT; err_code=01.
  3. Q_POP with count==0: no change; go to HALT; err_code=10.
  4. Q_GET_AND_PUSH with count<2: no change; go to HALT; err_code=10.
  5. Q_PUSH otherwise: mem[tail]<=result; tail+1; count+1.
  6. Q_POP otherwise: head+1; count-1.
  7. Q_GET_AND_PUSH otherwise: mem[tail]<=result; head+2; tail+1; count-1.
     - This is legal when full, because the net change is -1.
  8. Q_SLEEP: no change.
- In RUN with op_valid=0: nothing changes.
- In HALT:
  - All ops are ignored and the queue contents are frozen.
  - err_clr=1 returns to RUN with err_code=00 at the next edge.
  - If op_valid is also high in that cycle, the op is still ignored.
- Pointer arithmetic: head and tail are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. head+2 may wrap past DEPTH-1.
- Values: no saturation. Entries are stored verbatim and the ALU owns the arithmetic.
- Invariant: count always equals (tail-head) mod DEPTH, except when full, where count==DEPTH and tail==head.

Decomposition:
- A shared package `calc_pkg` holds:
  - the Q_* queue op codes;
  - the ALU opcode constants (PUSH..REM);
  - the err_code encodings;
  - the WIDTH constant.
  Both the ALU and calc_queue import it, so the codes cannot drift between the two blocks.
- Natural sub-module: `queue_mem`, a DEPTH x WIDTH register array.
  - One synchronous write port.
  - Two asynchronous read ports: addresses head and head+1.
- The FSM and pointer logic stay in calc_queue.

Test Plan (DEPTH=4):
- Reset, then PUSH 5 and PUSH 3 -> count=2, operands=16'h0305. Then GET_AND_PUSH with result 8 -> count=1, operands=16'h0008.
- PUSH 1,2,3,4 -> full=1. A fifth PUSH of 9 -> halted=1, err_code=01, count=4, operands=16'h0201.
- Starting full with 1,2,3,4: GET_AND_PUSH with result 7 -> count=3, operands=16'h0403. POP, POP -> operands=16'h0007, tail and head have wrapped.
- Empty queue, POP -> halted=1, err_code=10. err_clr together with a PUSH of 6 -> RUN, count=0. PUSH 6 -> count=1.
- count=1 with value 4: GET_AND_PUSH -> err_code=10, count=1. Separately, op_valid with has_calc_err=1 and PUSH -> err_code=11, no push.
- rst asserted in the same cycle as a PUSH while count=3 -> count=0, empty=1, halted=0, operands=0.

Source files
------------

// File: rtl/calc_pkg.sv
// Codes shared by the calculator ALU and its operand queue, so both blocks always agree on them.
// Contains queue op codes, ALU opcodes, halt causes and the datapath width.
package calc_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [1:0] {
        Q_PUSH         = 2'b00,
        Q_SLEEP        = 2'b01,
        Q_GET_AND_PUSH = 2'b10,
        Q_POP          = 2'b11
    } queue_op_e;

    typedef enum logic [2:0] {
        OP_PUSH = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MUL  = 3'd3,
        OP_DIV  = 3'd4,
        OP_REM  = 3'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_OVERFLOW  = 2'b01,
        ERR_UNDERFLOW = 2'b10,
        ERR_CALC      = 2'b11
    } err_code_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } q_state_e;

endpackage

// File: rtl/queue_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, two asynchronous read ports.
// Contents are deliberately not reset; occupancy logic upstream masks stale entries.
module queue_mem #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [WIDTH-1:0] i_wr_dat,
    input  logic [AW-1:0]    i_rd0_addr,
    output logic [WIDTH-1:0] o_rd0_dat,
    input  logic [AW-1:0]    i_rd1_addr,
    output logic [WIDTH-1:0] o_rd1_dat
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    assign o_rd0_dat = r_mem[i_rd0_addr];
    assign o_rd1_dat = r_mem[i_rd1_addr];

endmodule

// File: rtl/calc_queue.sv
// Circular operand queue fed by the ALU; presents the two head entries back to it. One-cycle latency.
// No backpressure: an illegal op (overflow, underflow, ALU error) halts the queue until err_clr.
module calc_queue
    import calc_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = calc_pkg::WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     op_valid,
    input  logic [1:0]               queue_op,
    input  logic [WIDTH-1:0]         result,
    input  logic                     has_calc_err,
    input  logic                     err_clr,
    output logic [2*WIDTH-1:0]       operands,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     halted,
    output logic [1:0]               err_code
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW-1:0] PTR_TWO   = AW'(2);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW:0]   CNT_TWO   = (AW+1)'(2);
    localparam logic [AW:0]   CNT_DEPTH = (AW+1)'(DEPTH);

    logic [AW-1:0] r_head, r_tail;
    logic [AW:0]   r_count;
    q_state_e      r_state;
    err_code_e     r_err;

    logic [AW-1:0]    w_head_nxt, w_tail_nxt, w_head_p1;
    logic [AW:0]      w_count_nxt;
    q_state_e         w_state_nxt;
    err_code_e        w_err_nxt;
    logic             w_wr_en, w_full;
    logic [WIDTH-1:0] w_rd0_dat, w_rd1_dat;

    assign w_head_p1 = r_head + PTR_ONE;
    assign w_full    = (r_count == CNT_DEPTH);

    queue_mem #(.DEPTH(DEPTH), .WIDTH(WIDTH), .AW(AW)) u_mem (
        .i_clk      (clk),
        .i_wr_en    (w_wr_en & ~rst),
        .i_wr_addr  (r_tail),
        .i_wr_dat   (result),
        .i_rd0_addr (r_head),
        .o_rd0_dat  (w_rd0_dat),
        .i_rd1_addr (w_head_p1),
        .o_rd1_dat  (w_rd1_dat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_state <= ST_RUN;
            r_err   <= ERR_NONE;
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_count <= w_count_nxt;
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Error checks take priority over the op itself; a failed op leaves the queue untouched.
    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        w_head_nxt  = r_head;
        w_tail_nxt  = r_tail;
        w_count_nxt = r_count;
        w_wr_en     = 1'b0;
        if (r_state == ST_HALT) begin
            if (err_clr) begin
                w_state_nxt = ST_RUN;
                w_err_nxt   = ERR_NONE;
            end
        end else if (op_valid) begin
            if (has_calc_err) begin
                w_state_nxt = ST_HALT;
                w_err_nxt   = ERR_CALC;
            end else if (queue_op == Q_PUSH && w_full) begin
                w_state_nxt = ST_HALT;
                w_err_nxt   = ERR_OVERFLOW;
            end else if ((queue_op == Q_POP && r_count == '0) ||
                         (queue_op == Q_GET_AND_PUSH && r_count < CNT_TWO)) begin
                w_state_nxt = ST_HALT;
                w_err_nxt   = ERR_UNDERFLOW;
            end else begin
                case (queue_op)
                    Q_PUSH: begin
                        w_wr_en     = 1'b1;
                        w_tail_nxt  = r_tail + PTR_ONE;
                        w_count_nxt = r_count + CNT_ONE;
                    end
                    Q_POP: begin
                        w_head_nxt  = w_head_p1;
                        w_count_nxt = r_count - CNT_ONE;
                    end
                    Q_GET_AND_PUSH: begin
                        w_wr_en     = 1'b1;
                        w_head_nxt  = r_head + PTR_TWO;
                        w_tail_nxt  = r_tail + PTR_ONE;
                        w_count_nxt = r_count - CNT_ONE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        halted   = (r_state == ST_HALT);
        err_code = r_err;
        count    = r_count;
        empty    = (r_count == '0);
        full     = w_full;
        operands = '0;
        if (r_count >= CNT_ONE) operands[WIDTH-1:0]       = w_rd0_dat;
        if (r_count >= CNT_TWO) operands[2*WIDTH-1:WIDTH] = w_rd1_dat;
    end

endmodule
